// File: rtl/coco_bus_phase_pkg.sv
// Shared definitions for the CoCo bus front end and the DMA/register engine.
package coco_bus_phase_pkg;

  // Bus phase encodings, named after which of E/Q is high.
  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    Q_HI    = 2'd1,
    EQ_HI   = 2'd2,
    E_HI    = 2'd3
  } phase_t;

  localparam logic [11:0] BASE_ADDR_DEF = 12'hFF6;

  // Register indices inside the FF6x window, shared with the DMA engine.
  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h1;
  localparam logic [3:0] REG_SRC_HI = 4'h2;
  localparam logic [3:0] REG_SRC_LO = 4'h3;
  localparam logic [3:0] REG_DST_HI = 4'h4;
  localparam logic [3:0] REG_DST_LO = 4'h5;
  localparam logic [3:0] REG_LEN_HI = 4'h6;
  localparam logic [3:0] REG_LEN_LO = 4'h7;
  localparam logic [3:0] REG_MODE   = 4'h8;
  localparam logic [3:0] REG_DATA   = 4'h9;
  localparam logic [3:0] REG_IRQ    = 4'hA;

  // Phase that a synchronised {e,q} pair encodes.
  function automatic phase_t pair2phase(input logic [1:0] eq);
    case (eq)
      2'b00:   return IDLE_LO;
      2'b01:   return Q_HI;
      2'b11:   return EQ_HI;
      default: return E_HI;
    endcase
  endfunction

  // Legal successor in the quadrature sequence.
  function automatic phase_t phase_succ(input phase_t p);
    case (p)
      IDLE_LO: return Q_HI;
      Q_HI:    return EQ_HI;
      EQ_HI:   return E_HI;
      default: return IDLE_LO;
    endcase
  endfunction

endpackage

// File: rtl/coco_bus_phase_sync_edge.sv
// N-stage synchroniser with registered one-clock rise/fall strobes.
module coco_bus_phase_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clock,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_first,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;
  logic              r_rise;
  logic              r_fall;

  // Shift the pin through the chain; strobes compare last stage with a delay flop.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_dly  <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_dly;
      r_fall <= ~r_sync[STAGES-1] & r_dly;
    end
  end

  assign o_first = r_sync[0];
  assign o_q     = r_sync[STAGES-1];
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/coco_bus_phase.sv
// CoCo cartridge bus front end: E/Q sync, phase tracking, FF6x write capture,
// E period measurement and stall / sequence-error detection.
module coco_bus_phase
  import coco_bus_phase_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          SYNC_STAGES = 2,
  parameter int          FAST_THRESH = 12,
  parameter int          TIMEOUT     = 255,
  parameter int          CNT_W       = 8
) (
  input  logic             clock,
  input  logic             _reset_cpu,
  input  logic             e_cpu,
  input  logic             q_cpu,
  input  logic             r_w_cpu,
  input  logic [15:0]      address_cpu,
  input  logic [7:0]       data_cpu,
  output logic             e_qual,
  output logic             q_qual,
  output logic             e_rise,
  output logic             e_fall,
  output logic             q_rise,
  output logic             q_fall,
  output logic [1:0]       phase,
  output logic             reg_wr,
  output logic             reg_rd,
  output logic [3:0]       reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             fast_mode,
  output logic [CNT_W-1:0] period,
  output logic             stall,
  output logic             seq_err
);

  localparam int                FILL_W = $clog2(SYNC_STAGES + 2);
  localparam logic [FILL_W-1:0] FILL_N = FILL_W'(SYNC_STAGES + 1);

  logic w_e_first, w_q_first_unused;

  coco_bus_phase_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_e (
    .i_clock(clock), .i_rst_n(_reset_cpu), .i_d(e_cpu),
    .o_first(w_e_first), .o_q(e_qual), .o_rise(e_rise), .o_fall(e_fall)
  );

  coco_bus_phase_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_q (
    .i_clock(clock), .i_rst_n(_reset_cpu), .i_d(q_cpu),
    .o_first(w_q_first_unused), .o_q(q_qual), .o_rise(q_rise), .o_fall(q_fall)
  );

  // ---------------- phase FSM ----------------
  phase_t r_phase, w_phase_nxt, w_tgt;
  logic   r_seq_err, w_seq_err_nxt;
  logic   r_cyc_ok, w_cyc_ok_nxt;
  logic   w_err_evt, r_err_evt;

  // State register; r_err_evt realigns the error event with the edge strobes.
  always_ff @(posedge clock or negedge _reset_cpu) begin
    if (!_reset_cpu) begin
      r_phase   <= IDLE_LO;
      r_seq_err <= 1'b0;
      r_cyc_ok  <= 1'b0;
      r_err_evt <= 1'b0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_seq_err <= w_seq_err_nxt;
      r_cyc_ok  <= w_cyc_ok_nxt;
      r_err_evt <= w_err_evt;
    end
  end

  // Follow the pair; illegal moves resync to the pair and flag an error.
  // r_cyc_ok marks a cycle that started legally from IDLE_LO.
  always_comb begin
    w_tgt         = pair2phase({e_qual, q_qual});
    w_phase_nxt   = r_phase;
    w_seq_err_nxt = r_seq_err;
    w_cyc_ok_nxt  = r_cyc_ok;
    w_err_evt     = 1'b0;
    if (w_tgt != r_phase) begin
      w_phase_nxt = w_tgt;
      if (w_tgt == phase_succ(r_phase)) begin
        if (r_phase == IDLE_LO) begin
          w_cyc_ok_nxt = 1'b1;
        end else if (r_phase == E_HI) begin
          w_cyc_ok_nxt = 1'b0;
          if (r_cyc_ok) w_seq_err_nxt = 1'b0;
        end
      end else begin
        w_err_evt     = 1'b1;
        w_seq_err_nxt = 1'b1;
        w_cyc_ok_nxt  = 1'b0;
      end
    end
  end

  assign phase   = r_phase;
  assign seq_err = r_seq_err;

  // ---------------- write capture ----------------
  logic [15:0]       r_smp_addr, r_sh_addr;
  logic [7:0]        r_smp_data, r_sh_data;
  logic              r_smp_rw, r_sh_rw;
  logic [FILL_W-1:0] r_fill;
  logic              r_low_ok, r_armed, r_err_hi;
  logic              r_reg_wr;
  logic [3:0]        r_reg_addr;
  logic [7:0]        r_reg_wdata;
  logic              w_wr_ok;

  // Bus is sampled on the same edge as E's first stage, so the shadow only
  // takes values that were seen together with E high.
  always_ff @(posedge clock or negedge _reset_cpu) begin
    if (!_reset_cpu) begin
      r_smp_addr <= '0;
      r_smp_data <= '0;
      r_smp_rw   <= 1'b0;
      r_sh_addr  <= '0;
      r_sh_data  <= '0;
      r_sh_rw    <= 1'b0;
    end else begin
      r_smp_addr <= address_cpu;
      r_smp_data <= data_cpu;
      r_smp_rw   <= r_w_cpu;
      if (w_e_first) begin
        r_sh_addr <= r_smp_addr;
        r_sh_data <= r_smp_data;
        r_sh_rw   <= r_smp_rw;
      end
    end
  end

  assign w_wr_ok = r_armed & ~r_sh_rw & (r_sh_addr[15:4] == BASE_ADDR)
                 & ~(r_err_hi | r_err_evt);

  // Arm only on an E rise preceded by a genuine low after the sync chain has
  // refilled, so a reset in mid E-high cannot produce a write.
  always_ff @(posedge clock or negedge _reset_cpu) begin
    if (!_reset_cpu) begin
      r_fill      <= '0;
      r_low_ok    <= 1'b0;
      r_armed     <= 1'b0;
      r_err_hi    <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
    end else begin
      if (r_fill != FILL_N) r_fill <= r_fill + 1'b1;
      else if (!e_qual)     r_low_ok <= 1'b1;
      if (r_err_evt)   r_err_hi <= 1'b1;
      else if (e_rise) r_err_hi <= 1'b0;
      if (e_fall)                  r_armed <= 1'b0;
      else if (e_rise && r_low_ok) r_armed <= 1'b1;
      r_reg_wr <= e_fall & w_wr_ok;
      if (e_fall && w_wr_ok) begin
        r_reg_addr  <= r_sh_addr[3:0];
        r_reg_wdata <= r_sh_data;
      end
    end
  end

  assign reg_wr    = r_reg_wr;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;
  assign reg_rd    = e_qual & r_w_cpu & (address_cpu[15:4] == BASE_ADDR);

  // ---------------- period / stall ----------------
  logic [CNT_W-1:0] r_pcnt, r_scnt, r_period;
  logic             r_seen_rise, r_fast;

  // Period counter restarts on each E rise; first rise after reset only restarts.
  always_ff @(posedge clock or negedge _reset_cpu) begin
    if (!_reset_cpu) begin
      r_pcnt      <= '0;
      r_period    <= '0;
      r_fast      <= 1'b0;
      r_seen_rise <= 1'b0;
    end else if (e_rise) begin
      r_pcnt      <= CNT_W'(1);
      r_seen_rise <= 1'b1;
      if (r_seen_rise) begin
        r_period <= r_pcnt;
        r_fast   <= (r_pcnt < CNT_W'(FAST_THRESH));
      end
    end else if (r_pcnt != '1) begin
      r_pcnt <= r_pcnt + CNT_W'(1);
    end
  end

  // Stall counter clears on any E edge and saturates otherwise.
  always_ff @(posedge clock or negedge _reset_cpu) begin
    if (!_reset_cpu)            r_scnt <= '0;
    else if (e_rise || e_fall)  r_scnt <= '0;
    else if (r_scnt != '1)      r_scnt <= r_scnt + CNT_W'(1);
  end

  assign period    = r_period;
  assign fast_mode = r_fast;
  assign stall     = (r_scnt >= CNT_W'(TIMEOUT));

endmodule

// File: tb/tb_coco_bus_phase.sv
// Scenario bench for coco_bus_phase: expected register writes are queued when
// the CPU write is driven and matched when reg_wr fires.
module tb_coco_bus_phase;

  logic        clock = 1'b0;
  logic        _reset_cpu;
  logic        e_cpu, q_cpu, r_w_cpu;
  logic [15:0] address_cpu;
  logic [7:0]  data_cpu;
  logic        e_qual, q_qual, e_rise, e_fall, q_rise, q_fall;
  logic [1:0]  phase;
  logic        reg_wr, reg_rd;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        fast_mode;
  logic [7:0]  period;
  logic        stall, seq_err;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  logic [11:0] sb[$];

  wire [32:0] w_obs = {e_qual, q_qual, e_rise, e_fall, q_rise, q_fall, phase,
                       reg_wr, reg_rd, reg_addr, reg_wdata, fast_mode, period,
                       stall, seq_err};

  coco_bus_phase dut (
    .clock(clock), ._reset_cpu(_reset_cpu), .e_cpu(e_cpu), .q_cpu(q_cpu),
    .r_w_cpu(r_w_cpu), .address_cpu(address_cpu), .data_cpu(data_cpu),
    .e_qual(e_qual), .q_qual(q_qual), .e_rise(e_rise), .e_fall(e_fall),
    .q_rise(q_rise), .q_fall(q_fall), .phase(phase), .reg_wr(reg_wr),
    .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .fast_mode(fast_mode), .period(period), .stall(stall), .seq_err(seq_err)
  );

  always #31 clock = ~clock;

  // Every reg_wr pulse must match the oldest expected write.
  always @(negedge clock) begin
    if (_reset_cpu === 1'b1 && reg_wr === 1'b1) begin
      logic [11:0] exp;
      wr_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_reg_wr got addr=%h data=%h, required no write", reg_addr, reg_wdata);
      end else begin
        exp = sb.pop_front();
        if ({reg_addr, reg_wdata} !== exp) begin
          failures++;
          $display("FAIL reg_wr_data got %h, required %h", {reg_addr, reg_wdata}, exp);
        end
      end
    end
  end

  // One E cycle, called at a negedge where E is due to fall; ends where the next E fall is due.
  task automatic bus_cycle(input bit fast, input logic [15:0] a, input logic [7:0] d, input logic rw);
    int n0, n1, n2, n3;
    n0 = fast ? 2 : 5; n1 = fast ? 2 : 4; n2 = fast ? 3 : 5; n3 = fast ? 2 : 4;
    e_cpu = 1'b0; q_cpu = 1'b0;
    #30;
    address_cpu = a; data_cpu = d; r_w_cpu = rw;
    repeat (n0) @(negedge clock);
    q_cpu = 1'b1;
    repeat (n1) @(negedge clock);
    e_cpu = 1'b1;
    if (!rw && a[15:4] == 12'hFF6) sb.push_back({a[3:0], d});
    repeat (n2) @(negedge clock);
    q_cpu = 1'b0;
    repeat (n3) @(negedge clock);
  endtask

  task automatic idle(input int n);
    e_cpu = 1'b0; q_cpu = 1'b0;
    #30;
    address_cpu = 16'h0000; data_cpu = 8'h00; r_w_cpu = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    _reset_cpu = 1'b0; e_cpu = 0; q_cpu = 0; r_w_cpu = 1; address_cpu = 0; data_cpu = 0;
    repeat (3) @(negedge clock);
    checks++;
    if (w_obs !== 33'd0) begin failures++; $display("FAIL reset_outputs got %h, required 0", w_obs); end
    _reset_cpu = 1'b1;
    repeat (6) @(negedge clock);
    checks++;
    if (w_obs !== 33'd0) begin failures++; $display("FAIL post_reset_idle got %h, required 0", w_obs); end
  endtask

  task automatic test_slow();
    int bad;
    logic [3:0] mask;
    logic [1:0] prev;
    bad = 0; mask = 4'h0; prev = phase;
    fork
      begin repeat (3) bus_cycle(0, 16'h1234, 8'h00, 1'b1); end
      begin
        repeat (54) begin
          @(negedge clock);
          mask[phase] = 1'b1;
          if (phase != prev && phase != prev + 2'd1) bad++;
          prev = phase;
        end
      end
    join
    checks++;
    if (bad != 0) begin failures++; $display("FAIL phase_order got %0d bad steps, required 0", bad); end
    checks++;
    if (mask !== 4'hF) begin failures++; $display("FAIL phase_coverage got %b, required 1111", mask); end
    checks++;
    if (period < 8'd17 || period > 8'd19) begin failures++; $display("FAIL slow_period got %0d, required 18+-1", period); end
    checks++;
    if (fast_mode !== 1'b0) begin failures++; $display("FAIL slow_fast_mode got %b, required 0", fast_mode); end
    checks++;
    if (seq_err !== 1'b0) begin failures++; $display("FAIL slow_seq_err got %b, required 0", seq_err); end
  endtask

  task automatic test_fast();
    repeat (3) bus_cycle(1, 16'h2000, 8'h00, 1'b1);
    checks++;
    if (period < 8'd8 || period > 8'd10) begin failures++; $display("FAIL fast_period got %0d, required 9+-1", period); end
    checks++;
    if (fast_mode !== 1'b1) begin failures++; $display("FAIL fast_mode got %b, required 1", fast_mode); end
  endtask

  task automatic test_write();
    int w0;
    w0 = wr_cnt;
    bus_cycle(0, 16'hFF69, 8'hA5, 1'b0);
    bus_cycle(0, 16'hFF79, 8'h3C, 1'b0);
    idle(8);
    checks++;
    if (wr_cnt - w0 != 1) begin failures++; $display("FAIL write_count got %0d, required 1", wr_cnt - w0); end
    checks++;
    if ({reg_addr, reg_wdata} !== 12'h9A5) begin failures++; $display("FAIL write_hold got %h, required 9a5", {reg_addr, reg_wdata}); end
  endtask

  task automatic test_read();
    address_cpu = 16'hFF62; r_w_cpu = 1'b1;
    q_cpu = 1'b1; repeat (4) @(negedge clock);
    e_cpu = 1'b1; repeat (4) @(negedge clock);
    checks++;
    if (reg_rd !== 1'b1) begin failures++; $display("FAIL reg_rd_window got %b, required 1", reg_rd); end
    address_cpu = 16'hFF72;
    #1;
    checks++;
    if (reg_rd !== 1'b0) begin failures++; $display("FAIL reg_rd_outside got %b, required 0", reg_rd); end
    @(negedge clock);
    q_cpu = 1'b0; repeat (4) @(negedge clock);
    idle(6);
  endtask

  task automatic test_stall();
    logic [7:0] p0;
    p0 = period;
    repeat (230) @(negedge clock);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL stall_early got %b, required 0", stall); end
    repeat (70) @(negedge clock);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL stall_set got %b, required 1", stall); end
    checks++;
    if (period !== p0) begin failures++; $display("FAIL stall_period_hold got %0d, required %0d", period, p0); end
    bus_cycle(0, 16'h0000, 8'h00, 1'b1);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL stall_clear got %b, required 0", stall); end
    idle(6);
  endtask

  task automatic test_seq_err();
    int w0;
    w0 = wr_cnt;
    address_cpu = 16'hFF61; data_cpu = 8'h77; r_w_cpu = 1'b0;
    e_cpu = 1'b1; q_cpu = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if (seq_err !== 1'b1) begin failures++; $display("FAIL seq_err_set got %b, required 1", seq_err); end
    checks++;
    if (phase !== 2'd2) begin failures++; $display("FAIL seq_resync_phase got %0d, required 2", phase); end
    q_cpu = 1'b0; repeat (4) @(negedge clock);
    idle(5);
    checks++;
    if (seq_err !== 1'b1) begin failures++; $display("FAIL seq_err_sticky got %b, required 1", seq_err); end
    checks++;
    if (wr_cnt != w0) begin failures++; $display("FAIL seq_err_write_blocked got %0d writes, required 0", wr_cnt - w0); end
    bus_cycle(0, 16'h0000, 8'h00, 1'b1);
    idle(6);
    checks++;
    if (seq_err !== 1'b0) begin failures++; $display("FAIL seq_err_clear got %b, required 0", seq_err); end
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = wr_cnt;
    address_cpu = 16'hFF60; data_cpu = 8'h5A; r_w_cpu = 1'b0;
    q_cpu = 1'b1; repeat (4) @(negedge clock);
    e_cpu = 1'b1; repeat (4) @(negedge clock);
    #10 _reset_cpu = 1'b0;
    #1;
    checks++;
    if (w_obs !== 33'd0) begin failures++; $display("FAIL mid_reset_outputs got %h, required 0", w_obs); end
    repeat (2) @(negedge clock);
    _reset_cpu = 1'b1;
    repeat (3) @(negedge clock);
    q_cpu = 1'b0; repeat (4) @(negedge clock);
    idle(8);
    checks++;
    if (wr_cnt != w0) begin failures++; $display("FAIL mid_reset_no_write got %0d writes, required 0", wr_cnt - w0); end
    bus_cycle(0, 16'hFF6A, 8'h3C, 1'b0);
    idle(8);
    checks++;
    if (wr_cnt != w0 + 1) begin failures++; $display("FAIL post_reset_write got %0d writes, required 1", wr_cnt - w0); end
  endtask

  initial begin
    test_reset();
    test_slow();
    test_fast();
    test_write();
    test_read();
    test_stall();
    test_seq_err();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL missing_reg_wr got %0d pending, required 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
